// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default operand width for the GCD engine
package gcd_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [2:0] {IDLE, GET_X, GET_Y, CALC, DONE} state_t;
endpackage

// File: rtl/gcd_step.sv
// gcd_step: one combinational binary-GCD iteration with its termination result
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int KW = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic [KW-1:0]    k_next,
    output logic             finish,
    output logic [WIDTH-1:0] result
);
    always_comb begin
        finish = a == '0 || b == '0;
        result = (a == '0 ? b : a) << k;
        a_next = a;
        b_next = b;
        k_next = k;
        if (!finish) begin
            // shared factors of two are stripped together and restored via k
            if (!a[0] && !b[0]) begin
                a_next = a >> 1;
                b_next = b >> 1;
                k_next = k + 1'b1;
            end
            else if (!a[0]) a_next = a >> 1;
            else if (!b[0]) b_next = b >> 1;
            else if (a >= b) a_next = a - b;
            else b_next = b - a;
        end
    end
endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: loads two operands serially and computes their GCD one binary step per cycle
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] gcd_result,
    output logic             done,
    output logic             busy
);
    localparam int KW = $clog2(WIDTH) + 1;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a, b, a_next, b_next, result;
    logic [KW-1:0] k, k_next;
    logic finish;

    gcd_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .a(a),
        .b(b),
        .k(k),
        .a_next(a_next),
        .b_next(b_next),
        .k_next(k_next),
        .finish(finish),
        .result(result)
    );

    assign done = state_q == DONE;
    assign busy = state_q inside {GET_X, GET_Y, CALC};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = load ? GET_X : state_q;
            GET_X:      state_d = GET_Y;
            GET_Y:      state_d = CALC;
            CALC:       state_d = load ? GET_X : finish ? DONE : CALC;
            default:    state_d = IDLE;
        endcase
    end

    // a load during CALC abandons the step and leaves gcd_result untouched
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a <= '0;
            b <= '0;
            k <= '0;
            gcd_result <= '0;
        end
        else begin
            if (state_q == GET_X) a <= data;
            if (state_q == GET_Y) begin
                b <= data;
                k <= '0;
            end
            if (state_q == CALC && !load) begin
                a <= a_next;
                b <= b_next;
                k <= k_next;
                if (finish) gcd_result <= result;
            end
        end
    end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: random and directed GCD operations checked against a Euclid reference model
module tb_gcd_engine;
    localparam int W = 8;
    localparam int LIMIT = 4 * W + 2;

    logic clock = 0;
    logic reset_n = 0;
    logic load = 0;
    logic [W-1:0] data = '0;
    logic [W-1:0] gcd_result;
    logic done, busy;

    int total = 0;
    int bad = 0;
    int done_rises = 0;
    logic [W-1:0] exp_gcd = '0;

    gcd_engine #(.WIDTH(W)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .load(load),
        .data(data),
        .gcd_result(gcd_result),
        .done(done),
        .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        int p = x, q = y, t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p[W-1:0];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // continuous scoreboard: exclusivity always, result whenever done is up
    initial begin
        logic prev_done = 0;
        forever begin
            @(posedge clock);
            #1;
            chk("done_busy_exclusive", int'(done && busy), 0);
            if (done) chk("model_result", gcd_result, exp_gcd);
            if (done && !prev_done) done_rises++;
            prev_done = done;
        end
    end

    // caller is positioned just after a falling edge
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit noisy);
        load = 1;
        @(negedge clock);
        load = 0;
        data = x;
        chk("busy_after_load", {30'd0, busy, done}, 2);
        @(negedge clock);
        data = y;
        load = noisy;
        exp_gcd = ref_gcd(x, y);
        @(negedge clock);
        load = 0;
        data = W'($urandom);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles <= LIMIT + 4) begin
            @(negedge clock);
            cycles++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input int exp_res, input int exp_cyc);
        int cyc;
        start_op(x, y, 0);
        wait_done(cyc);
        chk("cycle_bound", int'(cyc <= LIMIT), 1);
        if (exp_res >= 0) chk("literal_result", gcd_result, exp_res);
        if (exp_cyc >= 0) chk("literal_cycles", cyc, exp_cyc);
        chk("idle_after_done", int'(busy), 0);
        @(negedge clock);
    endtask

    initial begin
        int cyc, rises;
        #2;
        chk("reset_result", gcd_result, 0);
        chk("reset_flags", {30'd0, busy, done}, 0);
        @(negedge clock);
        reset_n = 1;
        run(8'd48, 8'd18, 6, -1);
        repeat (3) @(negedge clock);
        chk("done_held", int'(done), 1);
        chk("result_held", gcd_result, 6);
        run(8'd0, 8'd0, 0, 1);
        run(8'd0, 8'd25, 25, 1);
        run(8'd37, 8'd0, 37, 1);
        run(8'd255, 8'd255, 255, 2);
        run(8'd128, 8'd96, 32, -1);
        run(8'd1, 8'd254, 1, -1);
        rises = done_rises;
        start_op(8'd200, 8'd150, 0);
        repeat (2) @(negedge clock);
        start_op(8'd9, 8'd6, 0);
        wait_done(cyc);
        chk("abort_result", gcd_result, 3);
        @(negedge clock);
        chk("abort_single_done", done_rises - rises, 1);
        start_op(8'd84, 8'd36, 1);
        wait_done(cyc);
        chk("ignored_load_result", gcd_result, 12);
        @(negedge clock);
        start_op(8'd200, 8'd150, 0);
        @(negedge clock);
        #2;
        reset_n = 0;
        #1;
        chk("async_reset_result", gcd_result, 0);
        chk("async_reset_flags", {30'd0, busy, done}, 0);
        @(negedge clock);
        @(negedge clock);
        chk("reset_stays_idle", {30'd0, busy, done}, 0);
        reset_n = 1;
        run(8'd12, 8'd8, 4, -1);
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] x, y;
            x = W'($urandom);
            y = W'($urandom);
            if (i % 7 == 0) x = '0;
            if (i % 11 == 0) y = '0;
            if (i % 5 == 0) y = x << $urandom_range(0, 3);
            run(x, y, -1, -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load, input, 1 bit: one-cycle start pulse from the operand loader.
REQ-005 SHALL have port data, input, WIDTH bits: x on the cycle after load, y on the cycle after that.
REQ-006 SHALL have port gcd_result, output, WIDTH bits: registered GCD of the last completed operand pair.
REQ-007 SHALL have port done, output, 1 bit: high while gcd_result is valid.
REQ-008 SHALL have port busy, output, 1 bit: high from load acceptance until done rises.

Function
REQ-009 SHALL implement states IDLE, GET_X, GET_Y, CALC and DONE.
REQ-010 SHALL, in IDLE or DONE with load=1, go to GET_X, clear done and set busy on that edge.
REQ-011 SHALL, in GET_X, capture data into register a and go to GET_Y, ignoring load.
REQ-012 SHALL, in GET_Y, capture data into register b, clear shift count k to 0 and go to CALC.
REQ-013 SHALL, in CALC, apply exactly one step per cycle, using the first matching rule in this order:
- a==0: gcd_result<=b<<k, go to DONE.
- b==0: gcd_result<=a<<k, go to DONE.
- a and b both even: a>>=1, b>>=1, k++.
- a even: a>>=1.
- b even: b>>=1.
- a>=b: a<=a-b.
- otherwise: b<=b-a.
REQ-014 SHALL size k at clog2(WIDTH)+1 bits and perform all arithmetic unsigned at WIDTH bits; subtraction never underflows, by REQ-013 ordering.
REQ-015 SHALL return gcd(0,0)=0, gcd(0,y)=y and gcd(x,0)=x.
REQ-016 SHALL reach DONE no more than 4*WIDTH+2 cycles after entering CALC.
REQ-017 SHALL, in DONE, hold done=1, busy=0 and gcd_result stable until the next accepted load.
REQ-018 SHALL, on load=1 during CALC, abort the computation, go to GET_X and keep busy=1; gcd_result is not updated.
REQ-019 SHALL ignore load in GET_X and GET_Y.
REQ-020 SHALL assert done and busy mutually exclusively at all times.

Reset
REQ-021 SHALL, on reset_n=0 regardless of clock, force state=IDLE, a=0, b=0, k=0, gcd_result=0, done=0 and busy=0.
REQ-022 SHALL, on reset mid-operation (GET_X/GET_Y/CALC/DONE), discard all operands and wait for a fresh load after reset_n rises.
REQ-023 SHALL accept a load asserted in the first clock edge after reset_n deasserts.

Structure
REQ-024 SHALL take the state enum type and the default WIDTH constant from shared package gcd_pkg.
REQ-025 SHALL place the single-iteration step (REQ-013 rule selection) in combinational sub-module gcd_step; the sequencing FSM and registers stay in gcd_engine.

Verification
REQ-026 SHALL cover: load, x=48, y=18 -> done=1 within 34 CALC cycles, gcd_result=6, busy low.
REQ-027 SHALL cover: pairs (0,0), (0,25), (37,0) -> gcd_result 0, 25, 37 respectively, each completing in 1 CALC cycle.
REQ-028 SHALL cover: pairs (255,255), (128,96), (1,254) -> gcd_result 255, 32, 1; (255,255) takes 2 CALC cycles.
REQ-029 SHALL cover: load x=200, y=150, second load 3 cycles into CALC with x=9, y=6 -> single done, gcd_result=3.
REQ-030 SHALL cover: reset_n low mid-CALC -> outputs immediately 0/IDLE; next pair (12,8) -> gcd_result=4.
REQ-031 SHALL cover: load repeated every 2 cycles during GET_X/GET_Y -> ignored; operands taken from first load sequence.
